sha256_chunk_ctrl: RTL
======================

# sha256_chunk_ctrl

Sequencer for the SHA-256 message-schedule shift register and the round compressor. Accepts a stream of 32-bit message words (byte-reversed little-endian bus words) over a valid/ready handshake. Drives the schedule's clear/load/extend controls and issues one round strobe with round index 0..63 per schedule word to the compressor. Pulses hash init at message start, hash update after each chunk, and digest valid after the last chunk.

## Interface
- CHUNK_CNT_W, 16, width of the processed-chunk counter output
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  begin new message; accepted in any state
- dat_valid_i  in  1  upstream word valid
- dat_last_i  in  1  current chunk is the message's last; sampled on the 16th word handshake
- dat_ready_o  out  1  controller accepts a word
- sched_clear_o  out  1  to schedule `clear`
- sched_valid_o  out  1  to schedule `dat_vaild_i` = dat_valid_i & dat_ready_o
- sched_ninit_o  out  1  to schedule `proc_ninit` (extend/shift)
- round_valid_o  out  1  schedule output word is W[t] for round t
- round_idx_o  out  6  t, index for the K-constant ROM
- hash_init_o  out  1  load H0..H7 initial values
- hash_update_o  out  1  add working variables into H
- digest_valid_o  out  1  H holds the final digest
- busy_o  out  1  state != IDLE
- chunk_cnt_o  out  CHUNK_CNT_W  chunks completed since last start

## Operation
- States: IDLE, LOAD, ROUND, UPDATE, DONE. Word counter wcnt is 4 bits; round counter rcnt is 6 bits; last_r is 1 bit.
- Reset: state IDLE, wcnt=0, rcnt=0, last_r=0, chunk_cnt_o=0. All outputs are 0.
- start_i=1 in any state:
  - Same cycle: sched_clear_o=1, hash_init_o=1, dat_ready_o=0.
  - Next cycle: LOAD, with wcnt=0, rcnt=0, last_r=0, chunk_cnt_o=0.
  - start_i has priority over every other transition, including mid-ROUND abort.
- LOAD:
  - dat_ready_o=1. Each handshake increments wcnt.
  - The handshake at wcnt=15 captures last_r=dat_last_i and moves to ROUND next cycle.
  - dat_valid_i=0 holds the state indefinitely.
- ROUND:
  - round_valid_o=1, sched_ninit_o=1, round_idx_o=rcnt. Each advance increments rcnt.
  - At rcnt=63 with advance, move to UPDATE.
  - Schedule words generated beyond W[63] are don't-care.
- UPDATE (1 cycle):
  - hash_update_o=1, sched_clear_o=1, chunk_cnt_o increments (wraps at 2^CHUNK_CNT_W).
  - If last_r=1, go to DONE; else go to LOAD with wcnt=0, rcnt=0.
- DONE (1 cycle): digest_valid_o=1, then IDLE.
- dat_valid_i outside LOAD is ignored; dat_ready_o=0 there, so no word is lost or loaded.
- sched_valid_o and sched_ninit_o are never high together.

## Timing
- start_i is accepted at cycle 0. Words transfer on cycles 1..16 with valid held high.
- Rounds 0..63 occur on cycles 17..80; round t is on cycle 17+t.
- hash_update_o is high on cycle 81.
- For the last chunk, digest_valid_o is high on cycle 82 and IDLE is reached on cycle 83.
- For a non-last chunk, the next chunk's first word may transfer on cycle 82. The per-chunk cost is 81 cycles.
- sched_clear_o, hash_init_o, dat_ready_o and sched_valid_o are combinational from state and inputs. All other outputs are decoded from state or counters.

## Configuration
- SHA256_ROUND_STALL_EN defined:
  - Adds input round_ready_i (1 bit).
  - In ROUND, advance = round_ready_i.
  - sched_ninit_o = round_ready_i, so the schedule holds W[t] while stalled.
  - round_valid_o and round_idx_o stay stable until accepted.
- SHA256_ROUND_STALL_EN undefined:
  - No round_ready_i port.
  - Advance=1 every ROUND cycle; the compressor must consume one round per clock.

## Test plan
- Single chunk "abc": start_i at cycle 0.
  - Words on cycles 1..16: dat_lsb 0x80636261, 14× 0x00000000, then 0x18000000 with dat_last_i=1.
  - Expect round_idx_o 0..63 on cycles 17..80, hash_update_o at 81, digest_valid_o at 82, chunk_cnt_o=1.
  - With the schedule and compressor attached, expect digest ba7816bf…f20015ad.
- Two-chunk message with last=0 on the first chunk:
  - Expect hash_update_o at 81 and dat_ready_o=1 at 82.
  - Expect a second hash_update_o at 162, digest_valid_o at 163, chunk_cnt_o=2.
  - Expect exactly one hash_init_o.
- Bubbly input: dat_valid_i toggles 1/0 during LOAD.
  - Expect ROUND entered the cycle after the 16th handshake.
  - Expect sched_valid_o count=16 and no spurious sched_ninit_o.
- Abort: start_i asserted at round 30.
  - Expect sched_clear_o and hash_init_o that cycle, then LOAD with chunk_cnt_o=0.
  - Expect no hash_update_o for the aborted chunk.
- Reset: rst_n low mid-LOAD (wcnt=7).
  - Expect all outputs 0 immediately (async) and IDLE after release.
  - Expect dat_valid_i ignored until start_i.
- With SHA256_ROUND_STALL_EN: hold round_ready_i=0 for 5 cycles at round 10.
  - Expect round_idx_o=10 held for those cycles and sched_ninit_o=0 while stalled.
  - Expect hash_update_o delayed 5 cycles (cycle 86).

Source files
------------

// File: rtl/sha256_chunk_ctrl.sv
// SHA-256 chunk sequencer: loads 16 words per chunk, issues 64 round strobes, then updates H.
// Optional round back-pressure input is enabled by defining SHA256_ROUND_STALL_EN.
module sha256_chunk_ctrl #(
    parameter int unsigned CHUNK_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   dat_valid_i,
    input  logic                   dat_last_i,
`ifdef SHA256_ROUND_STALL_EN
    input  logic                   round_ready_i,
`endif
    output logic                   dat_ready_o,
    output logic                   sched_clear_o,
    output logic                   sched_valid_o,
    output logic                   sched_ninit_o,
    output logic                   round_valid_o,
    output logic [5:0]             round_idx_o,
    output logic                   hash_init_o,
    output logic                   hash_update_o,
    output logic                   digest_valid_o,
    output logic                   busy_o,
    output logic [CHUNK_CNT_W-1:0] chunk_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRound,
        StUpdate,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             wcnt_q, wcnt_d;
    logic [5:0]             rcnt_q, rcnt_d;
    logic                   last_q, last_d;
    logic [CHUNK_CNT_W-1:0] chunk_cnt_q, chunk_cnt_d;

    logic advance;
    logic in_load;
    logic in_round;
    logic word_hs;

`ifdef SHA256_ROUND_STALL_EN
    assign advance = round_ready_i;
`else
    assign advance = 1'b1;
`endif

    assign in_load  = (state_q == StLoad);
    assign in_round = (state_q == StRound);

    // A start in the same cycle blocks the word so a restart never loads stale data.
    assign dat_ready_o   = in_load & ~start_i;
    assign word_hs       = dat_valid_i & dat_ready_o;
    assign sched_valid_o = word_hs;
    assign sched_clear_o = start_i | (state_q == StUpdate);
    assign hash_init_o   = start_i;

    // Holding ninit low while stalled keeps W[t] on the schedule output.
    assign sched_ninit_o  = in_round & advance;
    assign round_valid_o  = in_round;
    assign round_idx_o    = rcnt_q;
    assign hash_update_o  = (state_q == StUpdate);
    assign digest_valid_o = (state_q == StDone);
    assign busy_o         = (state_q != StIdle);
    assign chunk_cnt_o    = chunk_cnt_q;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        last_d      = last_q;
        chunk_cnt_d = chunk_cnt_q;

        if (start_i) begin
            state_d     = StLoad;
            wcnt_d      = 4'd0;
            rcnt_d      = 6'd0;
            last_d      = 1'b0;
            chunk_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StLoad: begin
                    if (word_hs) begin
                        wcnt_d = wcnt_q + 4'd1;
                        if (wcnt_q == 4'd15) begin
                            last_d  = dat_last_i;
                            rcnt_d  = 6'd0;
                            state_d = StRound;
                        end
                    end
                end
                StRound: begin
                    if (advance) begin
                        rcnt_d = rcnt_q + 6'd1;
                        if (rcnt_q == 6'd63) begin
                            state_d = StUpdate;
                        end
                    end
                end
                StUpdate: begin
                    chunk_cnt_d = chunk_cnt_q + CHUNK_CNT_W'(1);
                    wcnt_d      = 4'd0;
                    rcnt_d      = 6'd0;
                    state_d     = last_q ? StDone : StLoad;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wcnt_q      <= 4'd0;
            rcnt_q      <= 6'd0;
            last_q      <= 1'b0;
            chunk_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            last_q      <= last_d;
            chunk_cnt_q <= chunk_cnt_d;
        end
    end

endmodule
